sj_poll_clock_gen: RTL and testbench

//  Programmable Sega-pad poll clock generator, successor to the fixed /121 divider.

---
 rtl/sj_pkg.sv | 17 +
 rtl/sj_hp_counter.sv | 64 ++++++
 rtl/sj_poll_clock_gen.sv | 157 +++++++++++++++
 tb/tb_sj_poll_clock_gen.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sj_pkg.sv
// rtl/sj_pkg.sv - shared types, defaults and divisor clamp for the Sega-pad poll clock
package sj_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } sj_poll_state_e;

    localparam int SJ_DIV_DEFAULT = 120;

    // A divisor of 0 would give a one-cycle half-period; the minimum usable is 1.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/sj_hp_counter.sv
// rtl/sj_hp_counter.sv - half-period counter with pending/bypass divisor reload
module sj_hp_counter
    import sj_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DIV_DEFAULT = SJ_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_run,
    input  logic             i_div_wr,
    input  logic [CNT_W-1:0] i_div_val,
    output logic             o_hp_end
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(clamp_div(32'(DIV_DEFAULT)));

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_div_pend;
    logic             r_pend;

    logic [CNT_W-1:0] w_div_wr_val;
    logic             w_hp_end;
    logic             w_apply;

    assign w_div_wr_val = CNT_W'(clamp_div(32'(i_div_val)));
    assign w_hp_end     = i_run && (r_cnt == r_div_act);
    // The active divisor only changes on a half-period boundary (or while idle),
    // so a half-period in flight is never truncated or stretched.
    assign w_apply      = w_hp_end || !i_run;
    assign o_hp_end     = w_hp_end;

    // Count 0..div_act while running; parked at 0 when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!i_run || w_hp_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Divisor reload: a write on the boundary cycle bypasses the pending slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_act  <= DIV_RST;
            r_div_pend <= '0;
            r_pend     <= 1'b0;
        end else if (w_apply) begin
            if (i_div_wr) begin
                r_div_act <= w_div_wr_val;
            end else if (r_pend) begin
                r_div_act <= r_div_pend;
            end
            r_pend <= 1'b0;
        end else if (i_div_wr) begin
            r_div_pend <= w_div_wr_val;
            r_pend     <= 1'b1;
        end
    end

endmodule

// File: rtl/sj_poll_clock_gen.sv
// rtl/sj_poll_clock_gen.sv - framed programmable SELECT clock generator for Sega pads
module sj_poll_clock_gen
    import sj_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DIV_DEFAULT = SJ_DIV_DEFAULT,
    parameter int PHASES      = 8,
    parameter int GAP_HP      = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      div_wr,
    input  logic [CNT_W-1:0]          div_val,
    output logic                      sj_clk,
    output logic                      tick,
    output logic [$clog2(PHASES)-1:0] phase,
    output logic                      frame_start,
    output logic                      frame_done,
    output logic                      busy
);

    localparam int                PH_W     = $clog2(PHASES);
    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(PHASES - 1);
    localparam int                GAP_W    = (GAP_HP > 1) ? $clog2(GAP_HP) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP_HP > 0) ? (GAP_HP - 1) : 0);

    if (((PHASES % 2) != 0) || (PHASES < 2)) begin : g_bad_phases
        $error("sj_poll_clock_gen: PHASES must be even and >= 2");
    end
    if (longint'(DIV_DEFAULT) >= (longint'(1) << CNT_W)) begin : g_bad_div
        $error("sj_poll_clock_gen: DIV_DEFAULT does not fit in CNT_W bits");
    end

    sj_poll_state_e   r_state;
    logic [PH_W-1:0]  r_phase;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_sj_clk;
    logic             r_tick;
    logic             r_frame_start;
    logic             r_frame_done;

    sj_poll_state_e   w_state_nx;
    logic [PH_W-1:0]  w_phase_nx;
    logic [GAP_W-1:0] w_gap_nx;
    logic             w_sj_nx;
    logic             w_tick_nx;
    logic             w_fs_nx;
    logic             w_fd_nx;
    logic             w_hp_end;
    logic             w_run;

    assign w_run = (r_state != IDLE);

    sj_hp_counter #(
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_hp_counter (
        .clk       (clk),
        .reset     (reset),
        .i_run     (w_run),
        .i_div_wr  (div_wr),
        .i_div_val (div_val),
        .o_hp_end  (w_hp_end)
    );

    // Next-state and registered-output logic for the IDLE/RUN/GAP frame sequencer.
    always_comb begin
        w_state_nx = r_state;
        w_phase_nx = r_phase;
        w_gap_nx   = r_gap_cnt;
        w_sj_nx    = r_sj_clk;
        w_tick_nx  = 1'b0;
        w_fs_nx    = 1'b0;
        w_fd_nx    = 1'b0;
        case (r_state)
            IDLE: begin
                w_phase_nx = '0;
                w_sj_nx    = 1'b0;
                if (en) begin
                    w_state_nx = RUN;
                    w_fs_nx    = 1'b1;
                end
            end
            RUN: begin
                if (w_hp_end) begin
                    w_sj_nx   = ~r_sj_clk;
                    w_tick_nx = 1'b1;
                    if (r_phase == PH_LAST) begin
                        // PHASES is even, so SELECT is back low here.
                        w_fd_nx    = 1'b1;
                        w_phase_nx = '0;
                        w_gap_nx   = '0;
                        if (GAP_HP > 0) begin
                            w_state_nx = GAP;
                        end else if (en) begin
                            w_state_nx = RUN;
                            w_fs_nx    = 1'b1;
                        end else begin
                            w_state_nx = IDLE;
                        end
                    end else begin
                        w_phase_nx = r_phase + 1'b1;
                    end
                end
            end
            GAP: begin
                w_sj_nx = 1'b0;
                if (w_hp_end) begin
                    if (r_gap_cnt == GAP_LAST) begin
                        w_gap_nx = '0;
                        if (en) begin
                            w_state_nx = RUN;
                            w_fs_nx    = 1'b1;
                        end else begin
                            w_state_nx = IDLE;
                        end
                    end else begin
                        w_gap_nx = r_gap_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops SELECT immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_phase       <= '0;
            r_gap_cnt     <= '0;
            r_sj_clk      <= 1'b0;
            r_tick        <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_phase       <= w_phase_nx;
            r_gap_cnt     <= w_gap_nx;
            r_sj_clk      <= w_sj_nx;
            r_tick        <= w_tick_nx;
            r_frame_start <= w_fs_nx;
            r_frame_done  <= w_fd_nx;
        end
    end

    assign sj_clk      = r_sj_clk;
    assign tick        = r_tick;
    assign phase       = r_phase;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign busy        = w_run;

endmodule

// File: tb/tb_sj_poll_clock_gen.sv
// tb/tb_sj_poll_clock_gen.sv - self-checking bench for sj_poll_clock_gen
module tb_sj_poll_clock_gen;

    localparam int CNT_W       = 8;
    localparam int DIV_DEFAULT = 120;
    localparam int PHASES      = 8;
    localparam int GAP_HP      = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             div_wr;
    logic [CNT_W-1:0] div_val;
    logic             sj_clk;
    logic             tick;
    logic [2:0]       phase;
    logic             frame_start;
    logic             frame_done;
    logic             busy;

    always #5 clk = ~clk;

    sj_poll_clock_gen #(
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DIV_DEFAULT),
        .PHASES      (PHASES),
        .GAP_HP      (GAP_HP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .div_wr      (div_wr),
        .div_val     (div_val),
        .sj_clk      (sj_clk),
        .tick        (tick),
        .phase       (phase),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int q_tick[$];
    int q_fs[$];
    int q_fd[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Behavioural model: countdown of cycles left in the current half-period.
    int   m_mode;   // 0 idle, 1 run, 2 gap
    int   m_left;
    int   m_div;
    int   m_pend;
    int   m_pend_val;
    int   m_hp;
    int   m_g;
    int   m_phase;
    logic m_sj, m_tick, m_fs, m_fd;

    function automatic int clampv(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic m_start_frame();
        m_mode  = 1;
        m_fs    = 1'b1;
        m_hp    = 0;
        m_phase = 0;
        m_left  = m_div + 1;
    endtask

    task automatic m_next_or_idle();
        if (en) m_start_frame();
        else    m_mode = 0;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_left = 0; m_div = DIV_DEFAULT; m_pend = 0; m_pend_val = 0;
            m_hp = 0; m_g = 0; m_phase = 0;
            m_sj = 1'b0; m_tick = 1'b0; m_fs = 1'b0; m_fd = 1'b0;
        end else begin : step
            bit end_hp;
            end_hp = (m_mode != 0) && (m_left == 1);
            if (end_hp || m_mode == 0) begin
                if (div_wr) m_div = clampv(int'(div_val));
                else if (m_pend != 0) m_div = m_pend_val;
                m_pend = 0;
            end else if (div_wr) begin
                m_pend_val = clampv(int'(div_val));
                m_pend     = 1;
            end
            m_tick = 1'b0; m_fs = 1'b0; m_fd = 1'b0;
            case (m_mode)
                0: begin
                    m_sj = 1'b0; m_phase = 0;
                    if (en) m_start_frame();
                end
                1: begin
                    if (end_hp) begin
                        m_sj = ~m_sj; m_tick = 1'b1; m_hp++;
                        if (m_hp == PHASES) begin
                            m_fd = 1'b1; m_phase = 0;
                            if (GAP_HP > 0) begin
                                m_mode = 2; m_g = 0; m_left = m_div + 1;
                            end else begin
                                m_next_or_idle();
                            end
                        end else begin
                            m_phase = m_hp; m_left = m_div + 1;
                        end
                    end else begin
                        m_left--;
                    end
                end
                default: begin
                    if (end_hp) begin
                        m_g++;
                        if (m_g == GAP_HP) m_next_or_idle();
                        else               m_left = m_div + 1;
                    end else begin
                        m_left--;
                    end
                end
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        n_checks++;
        if ({sj_clk, tick, phase, frame_start, frame_done, busy} !==
            {m_sj, m_tick, 3'(m_phase), m_fs, m_fd, (m_mode != 0)}) begin
            n_fail++;
            $display("FAIL model cyc=%0d got sj=%b tick=%b ph=%0d fs=%b fd=%b busy=%b, expected sj=%b tick=%b ph=%0d fs=%b fd=%b busy=%b",
                     cyc, sj_clk, tick, phase, frame_start, frame_done, busy,
                     m_sj, m_tick, m_phase, m_fs, m_fd, (m_mode != 0));
        end
    end

    // Event logger: cycle stamps of strobes, for hand-computed timing checks.
    always @(negedge clk) begin
        if (tick === 1'b1)        q_tick.push_back(cyc);
        if (frame_start === 1'b1) q_fs.push_back(cyc);
        if (frame_done === 1'b1)  q_fd.push_back(cyc);
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_div(input logic [CNT_W-1:0] v);
        div_wr  = 1'b1;
        div_val = v;
        @(negedge clk);
        div_wr  = 1'b0;
        div_val = '0;
    endtask

    int t0, t1, t2, t3, c, c4;
    int off2[8] = '{121, 125, 129, 131, 133, 135, 145, 155};

    initial begin
        reset = 1'b1; en = 1'b0; div_wr = 1'b0; div_val = '0;
        repeat (3) @(negedge clk);
        chk("rst_sj_clk", int'(sj_clk), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_phase", int'(phase), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_no_fs", q_fs.size(), 0);

        // Default divisor: 121-cycle half-periods, 242-cycle gap.
        c  = cyc;
        en = 1'b1;
        wait_cyc(c + 1 + 1215);
        t0 = q_fs[0];
        chk("t0", t0, c + 1);
        for (int k = 1; k <= 8; k++) chk($sformatf("f1_tick%0d", k), q_tick[k-1], t0 + 121 * k);
        chk("f1_done", q_fd[0], t0 + 968);
        chk("f2_start", q_fs[1], t0 + 1210);
        t1 = t0 + 1210;

        // Pending write mid half-period, clamp of 0, and boundary bypass of 9.
        wait_cyc(t1 + 50);
        pulse_div(8'd3);
        wait_cyc(t1 + 126);
        pulse_div(8'd0);
        wait_cyc(t1 + 134);
        pulse_div(8'd9);
        wait_cyc(t1 + 180);
        for (int k = 0; k < 8; k++) chk($sformatf("f2_tick%0d", k + 1), q_tick[8 + k], t1 + off2[k]);
        chk("f2_done", q_fd[1], t1 + 155);
        chk("f3_start", q_fs[2], t1 + 175);
        t2 = t1 + 175;

        // Drop en during phase 3: frame and gap complete, then idle.
        wait_cyc(t2 + 33);
        en = 1'b0;
        wait_cyc(t2 + 160);
        for (int k = 1; k <= 8; k++) chk($sformatf("f3_tick%0d", k), q_tick[15 + k], t2 + 10 * k);
        chk("f3_done", q_fd[2], t2 + 80);
        chk("f3_no_restart", q_fs.size(), 3);
        chk("f3_idle_busy", int'(busy), 0);
        chk("f3_idle_sj", int'(sj_clk), 0);

        // Asynchronous reset mid-RUN while SELECT is high.
        c  = cyc;
        en = 1'b1;
        t3 = c + 1;
        wait_cyc(t3 + 13);
        chk("f4_start", q_fs[3], t3);
        chk("pre_rst_sj", int'(sj_clk), 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_sj_clk", int'(sj_clk), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_phase", int'(phase), 0);
        chk("arst_fs", int'(frame_start), 0);
        chk("arst_fd", int'(frame_done), 0);
        chk("arst_tick", int'(tick), 0);
        repeat (2) @(negedge clk);
        c4    = cyc;
        reset = 1'b0;
        wait_cyc(c4 + 1 + 125);
        chk("post_rst_fs", q_fs[q_fs.size() - 1], c4 + 1);
        chk("post_rst_tick", q_tick[q_tick.size() - 1], c4 + 1 + 121);
        chk("post_rst_tick_cnt", q_tick.size(), 26);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
